cbus_clint: RTL
===============

Name: cbus_clint

Overview:
- CBus responder implementing a CLINT-style timer and software-interrupt device.
- Sits on the device side of the CBus arbiter, alongside the RAM model.
- Accepts single-beat and burst requests.
- Holds msip, mtimecmp and a free-running mtime; drives the core's trint and swint.

Parameters:
- TICK_DIV, 1: clock cycles per mtime increment; must be >= 1.
- OFS_MSIP, 16'h0000: offset of msip within the 64 KiB window.
- OFS_MTIMECMP, 16'h4000: offset of mtimecmp.
- OFS_MTIME, 16'hBFF8: offset of mtime.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low: device state resets on a rising edge of clk while reset==0
- creq  in  cbus_req_t  request from arbiter (valid, is_write, size, addr, strobe, data, len, burst)
- cresp  out  cbus_resp_t  response (ready, last, data)
- trint  out  1  timer interrupt, level
- swint  out  1  software interrupt, level

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, cresp='0.
  - msip=0, mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, tick counter=0.
  - Consequently trint=0 and swint=0.
- Address decode:
  - Only addr[15:3] is used; beats are 8-byte aligned and addr[2:0] is ignored.
  - Byte lanes are selected by strobe; size is ignored.
  - msip is 32 bits in lanes 3:0, upper lanes read 0. Only bit 0 is stored; bits 31:1 read 0.
  - Unmapped offsets read 64'h0 and ignore writes.
- FSM IDLE:
  - cresp.ready=0.
  - On creq.valid=1: latch addr, len, is_write, burst; clear beat count; go to ACTIVE next cycle.
  - First-beat latency is therefore 1 cycle.
- FSM ACTIVE:
  - cresp.ready=1 every cycle; one beat per cycle.
  - cresp.data is combinational from the register at the current beat address.
  - On a write beat, the register is updated at the clock edge using creq.data/strobe; the write is visible on the next read beat.
  - cresp.last=1 when beat count==latched len.
  - On the last beat, go to IDLE. The responder does not accept a new request in the cycle after last; one idle cycle minimum.
  - If creq.valid drops mid-burst (protocol violation): abort to IDLE next cycle with no write on that cycle.
- Burst address update after each beat:
  - INCR: addr+=8.
  - FIXED: addr unchanged.
  - WRAP: addr[6:3] wraps within the (len+1)*8-byte aligned block.
- mtime:
  - Tick counter counts 0..TICK_DIV-1; mtime+=1 (mod 2^64) on wrap.
  - Counting continues during transactions.
  - A write to mtime in the same cycle as an increment: the write wins and the increment is dropped.
  - A partial-strobe mtime write merges unwritten lanes from the current mtime value (no increment).
- Interrupts:
  - trint = (mtime >= mtimecmp), unsigned compare, registered: changes 1 cycle after the register change.
  - swint = msip[0], direct from the register.
- Width rules: all arithmetic is 64-bit unsigned; mtime rolls from FFFF_FFFF_FFFF_FFFF to 0 and trint reevaluates.
- Reset asserted mid-burst: next cycle ready=0, last=0 and all registers hold reset values. The initiator must reissue the request.

Decomposition:
- Add to common package:
  - localparams CLINT_OFS_MSIP, CLINT_OFS_MTIMECMP, CLINT_OFS_MTIME.
  - typedef clint_state_t enum {CLINT_IDLE, CLINT_ACTIVE}.
  - Function strobe_merge(u64 old, u64 wdata, u8 strobe) returning u64.
- One natural sub-module: clint_timer (tick prescaler, mtime register, write override, trint compare).
- Bus FSM and decode stay in cbus_clint.

Test Plan:
- Reset hold:
  - Stimulus: reset=0 for 3 cycles, then reset=1 with creq idle.
  - Required: cresp='0, trint=0, swint=0, and mtime read back at cycle 10 is within [8,10] for TICK_DIV=1.
- Single write/read msip:
  - Stimulus: write addr 0x0200_0000, data 1, strobe 8'h0F, len MLEN1.
  - Required: ready and last on the same beat, one cycle after valid; swint=1 the following cycle; read returns 64'h1.
- Timer interrupt:
  - Stimulus: write mtimecmp=20 with mtime~0 (TICK_DIV=1).
  - Required: trint rises exactly 1 cycle after mtime reaches 20.
  - Then write mtimecmp=FFFF..FF: trint=0 one cycle later.
- Burst INCR read, len MLEN4 from 0x0200_BFE8:
  - Required: 4 consecutive ready beats, last only on beat 4.
  - Beats 1-2 read 0 (unmapped); beat 3 reads mtime; beat 4 reads 0.
- Write/increment collision:
  - Stimulus: write mtime=64'hFFFF_FFFF_FFFF_FFFE with strobe FF on a tick cycle.
  - Required: reads FFFF..FFFE then FFFF..FFFF, then wraps to 0.
  - trint follows the compare against mtimecmp=5 (1 at wrap-over only after mtime>=5).
- Mid-burst abort and reset:
  - Stimulus: drop valid on beat 2 of an MLEN8 write to mtimecmp.
  - Required: FSM returns to IDLE and only beat 1's data is written.
  - Repeat with reset=0 asserted on beat 2: next cycle ready=0 and mtimecmp=all ones.

Source files
------------

// File: rtl/cbus_clint_pkg.sv
// Shared CBus types plus the CLINT register map, FSM states and byte-lane merge helper.
package cbus_clint_pkg;

    typedef logic [63:0] u64;
    typedef logic [7:0]  u8;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } cbus_burst_t;

    // len encodes beats-1; wrap bursts rely on len+1 being a power of two
    localparam logic [3:0] MLEN1  = 4'd0;
    localparam logic [3:0] MLEN2  = 4'd1;
    localparam logic [3:0] MLEN4  = 4'd3;
    localparam logic [3:0] MLEN8  = 4'd7;
    localparam logic [3:0] MLEN16 = 4'd15;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [3:0]  len;
        cbus_burst_t burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    localparam logic [15:0] CLINT_OFS_MSIP     = 16'h0000;
    localparam logic [15:0] CLINT_OFS_MTIMECMP = 16'h4000;
    localparam logic [15:0] CLINT_OFS_MTIME    = 16'hBFF8;

    typedef enum logic {
        CLINT_IDLE   = 1'b0,
        CLINT_ACTIVE = 1'b1
    } clint_state_t;

    function automatic u64 strobe_merge(u64 old, u64 wdata, u8 strobe);
        u64 r;
        for (int i = 0; i < 8; i++) begin
            r[i*8 +: 8] = strobe[i] ? wdata[i*8 +: 8] : old[i*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/cbus_clint_timer.sv
// CLINT timer: tick prescaler, free-running mtime with bus write override, registered trint compare.
module cbus_clint_timer
    import cbus_clint_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic wr_en_i,
    input  u64   wdata_i,
    input  u8    strobe_i,
    input  u64   mtimecmp_i,
    output u64   mtime_o,
    output logic trint_o
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] tick_q, tick_d;
    u64            mtime_q, mtime_d;
    logic          trint_q;
    logic          tick_wrap;

    // a bus write replaces the value outright, swallowing any coincident tick
    always_comb begin
        tick_wrap = (tick_q == TICK_LAST);
        tick_d    = tick_wrap ? '0 : tick_q + 1'b1;
        mtime_d   = mtime_q;
        if (wr_en_i) begin
            mtime_d = strobe_merge(mtime_q, wdata_i, strobe_i);
        end else if (tick_wrap) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_q  <= '0;
            mtime_q <= '0;
            trint_q <= 1'b0;
        end else begin
            tick_q  <= tick_d;
            mtime_q <= mtime_d;
            trint_q <= (mtime_q >= mtimecmp_i);
        end
    end

    assign mtime_o = mtime_q;
    assign trint_o = trint_q;

endmodule

// File: rtl/cbus_clint.sv
// CBus responder for the CLINT: bus FSM, register decode, msip/mtimecmp storage.
//   state        | meaning
//   CLINT_IDLE   | ready=0, waiting for creq.valid to latch a request
//   CLINT_ACTIVE | one beat per cycle until last beat or valid drops
module cbus_clint
    import cbus_clint_pkg::*;
#(
    parameter int          TICK_DIV     = 1,
    parameter logic [15:0] OFS_MSIP     = CLINT_OFS_MSIP,
    parameter logic [15:0] OFS_MTIMECMP = CLINT_OFS_MTIMECMP,
    parameter logic [15:0] OFS_MTIME    = CLINT_OFS_MTIME
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp,
    output logic       trint,
    output logic       swint
);

    clint_state_t state_q;
    logic [15:3]  addr_q, addr_d;
    logic [3:0]   len_q;
    logic [3:0]   beat_q;
    logic         wr_q;
    cbus_burst_t  burst_q;
    logic         msip_q;
    u64           mtimecmp_q;
    u64           mtime;
    u64           rdata;

    logic         sel_msip, sel_cmp, sel_mtime;
    logic         beat_wr, beat_last;
    logic [3:0]   wrap_idx;
    logic         unused_req_bits;

    assign unused_req_bits = ^{creq.size, creq.addr[31:16], creq.addr[2:0]};

    always_comb begin
        sel_msip  = (addr_q == OFS_MSIP[15:3]);
        sel_cmp   = (addr_q == OFS_MTIMECMP[15:3]);
        sel_mtime = (addr_q == OFS_MTIME[15:3]);
        beat_wr   = (state_q == CLINT_ACTIVE) && creq.valid && wr_q;
        beat_last = (beat_q == len_q);

        // wrap keeps the bits above the block, increments only the bits inside it
        wrap_idx = (addr_q[6:3] & ~len_q) | ((addr_q[6:3] + 4'd1) & len_q);
        case (burst_q)
            BURST_INCR: addr_d = addr_q + 13'd1;
            BURST_WRAP: addr_d = {addr_q[15:7], wrap_idx};
            default:    addr_d = addr_q;
        endcase

        rdata = '0;
        if (sel_msip) begin
            rdata = {63'd0, msip_q};
        end else if (sel_cmp) begin
            rdata = mtimecmp_q;
        end else if (sel_mtime) begin
            rdata = mtime;
        end

        cresp = '0;
        if (state_q == CLINT_ACTIVE) begin
            cresp.ready = 1'b1;
            cresp.last  = beat_last;
            cresp.data  = rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= CLINT_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            wr_q       <= 1'b0;
            burst_q    <= BURST_FIXED;
            msip_q     <= 1'b0;
            mtimecmp_q <= '1;
        end else begin
            case (state_q)
                CLINT_IDLE: begin
                    if (creq.valid) begin
                        addr_q  <= creq.addr[15:3];
                        len_q   <= creq.len;
                        wr_q    <= creq.is_write;
                        burst_q <= creq.burst;
                        beat_q  <= '0;
                        state_q <= CLINT_ACTIVE;
                    end
                end
                CLINT_ACTIVE: begin
                    if (!creq.valid || beat_last) begin
                        state_q <= CLINT_IDLE;
                    end else begin
                        beat_q <= beat_q + 4'd1;
                        addr_q <= addr_d;
                    end
                end
                default: state_q <= CLINT_IDLE;
            endcase

            if (beat_wr && sel_msip && creq.strobe[0]) begin
                msip_q <= creq.data[0];
            end
            if (beat_wr && sel_cmp) begin
                mtimecmp_q <= strobe_merge(mtimecmp_q, creq.data, creq.strobe);
            end
        end
    end

    cbus_clint_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .wr_en_i    (beat_wr && sel_mtime),
        .wdata_i    (creq.data),
        .strobe_i   (creq.strobe),
        .mtimecmp_i (mtimecmp_q),
        .mtime_o    (mtime),
        .trint_o    (trint)
    );

    assign swint = msip_q;

endmodule
